// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store bridge: funct3 codes,
// opcodes, FSM encoding and the store-side lane helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // Loads always fetch the whole word; only stores narrow the enables.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
    logic [3:0] be;
    be = 4'b1111;
    case (f3)
      F3_B: be = 4'b0001 << a;
      F3_H: begin
        case (a)
          2'b00:   be = 4'b0011;
          2'b01:   be = 4'b0110;
          2'b10:   be = 4'b1100;
          default: be = 4'b1000;
        endcase
      end
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_rotate(input logic [31:0] d, input logic [1:0] a);
    logic [31:0] r;
    case (a)
      2'b00:   r = d;
      2'b01:   r = {d[23:0], d[31:24]};
      2'b10:   r = {d[15:0], d[31:16]};
      default: r = {d[7:0], d[31:8]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Extracts the addressed byte/half from a read word and sign/zero-extends it;
// word loads and unrecognised funct3 values pass the word through.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] word,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo)
      2'b00:   byte_sel = word[7:0];
      2'b01:   byte_sel = word[15:8];
      2'b10:   byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword lane comes from a[1] alone; a[0] is don't-care.
    half_sel = addr_lo[1] ? word[31:16] : word[15:0];

    result = word;
    case (funct3)
      F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   result = {24'h000000, byte_sel};
      F3_H:    result = {{16{half_sel[15]}}, half_sel};
      F3_HU:   result = {16'h0000, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/lsu_mem_bridge.sv
// M-stage load/store unit driving a req/gnt + rvalid data memory port.
// Optional LSU_MISALIGN_CHK_EN: misaligned h/w accesses complete without a bus request.
module lsu_mem_bridge
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 255,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_valid,
  input  logic              m_we,
  input  logic [2:0]        m_funct3,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [31:0]       m_wdata,
  output logic              stall_m,
  output logic [31:0]       load_data,
  output logic              done_m,
  output logic              bus_err,
`ifdef LSU_MISALIGN_CHK_EN
  output logic              misalign,
`endif
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [31:0]       load_data_q, load_data_d;
  logic              bus_err_q, bus_err_d;
  logic [7:0]        wait_cnt_q, wait_cnt_d;
  logic              misalign_q, misalign_d;
  logic              timeout;
  logic              is_misaligned;
  logic [31:0]       aligned_rdata;

  lsu_load_align u_load_align (
    .funct3  (funct3_q),
    .addr_lo (addr_lo_q),
    .word    (mem_rdata),
    .result  (aligned_rdata)
  );

  assign timeout = (wait_cnt_q == 8'(MAX_WAIT - 1));

  always_comb begin
    is_misaligned = 1'b0;
    if (m_funct3[1:0] == F3_H[1:0])
      is_misaligned = m_addr[0];
    else if (m_funct3 == F3_W)
      is_misaligned = (m_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    load_data_d = load_data_q;
    bus_err_d   = 1'b0;
    misalign_d  = 1'b0;
    wait_cnt_d  = wait_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (m_valid) begin
          mem_we_d    = m_we;
          mem_addr_d  = {m_addr[ADDR_W-1:2], 2'b00};
          mem_be_d    = m_we ? store_be(m_funct3, m_addr[1:0]) : 4'b1111;
          mem_wdata_d = store_rotate(m_wdata, m_addr[1:0]);
          funct3_d    = m_funct3;
          addr_lo_d   = m_addr[1:0];
          wait_cnt_d  = 8'd0;
`ifdef LSU_MISALIGN_CHK_EN
          if (is_misaligned) begin
            load_data_d = 32'h0;
            misalign_d  = 1'b1;
            state_d     = ST_DONE;
          end else begin
            mem_req_d = 1'b1;
            state_d   = ST_REQ;
          end
`else
          mem_req_d = 1'b1;
          state_d   = ST_REQ;
`endif
        end
      end
      ST_REQ: begin
        // A grant in the final allowed cycle still wins over the timeout.
        if (mem_gnt) begin
          mem_req_d  = 1'b0;
          wait_cnt_d = 8'd0;
          state_d    = mem_we_q ? ST_DONE : ST_WAIT;
        end else if (timeout) begin
          mem_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          load_data_d = 32'h0;
          state_d     = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          load_data_d = aligned_rdata;
          state_d     = ST_DONE;
        end else if (timeout) begin
          bus_err_d   = 1'b1;
          load_data_d = 32'h0;
          state_d     = ST_DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      load_data_q <= 32'h0;
      bus_err_q   <= 1'b0;
      wait_cnt_q  <= 8'd0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      load_data_q <= load_data_d;
      bus_err_q   <= bus_err_d;
      wait_cnt_q  <= wait_cnt_d;
      misalign_q  <= misalign_d;
    end
  end

  // The pipeline stays frozen from the first M cycle until the DONE cycle.
  assign stall_m   = (m_valid && state_q == ST_IDLE) || state_q == ST_REQ || state_q == ST_WAIT;
  assign done_m    = (state_q == ST_DONE);
  assign load_data = load_data_q;
  assign bus_err   = bus_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;
`ifdef LSU_MISALIGN_CHK_EN
  assign misalign  = misalign_q;
`else
  logic unused_misalign;
  assign unused_misalign = misalign_q ^ is_misaligned;
`endif

endmodule

// File: tb/tb_lsu_mem_bridge.sv
// Directed bench for lsu_mem_bridge: a driver plays the M stage and memory,
// a negedge monitor checks bus requests and completions against queues.
module tb_lsu_mem_bridge;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_valid = 1'b0;
  logic        m_we = 1'b0;
  logic [2:0]  m_funct3 = 3'b000;
  logic [31:0] m_addr = 32'h0;
  logic [31:0] m_wdata = 32'h0;
  logic        stall_m;
  logic [31:0] load_data;
  logic        done_m;
  logic        bus_err;
`ifdef LSU_MISALIGN_CHK_EN
  logic        misalign;
`endif
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  // bus entry: {we, addr, be, wdata}; done entry: {is_load, err, data}
  logic [68:0] exp_bus_q[$];
  logic [33:0] exp_done_q[$];
  int check_cnt = 0;
  int pass_cnt  = 0;

  lsu_mem_bridge #(.MAX_WAIT(MAXW), .ADDR_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .m_valid    (m_valid),
    .m_we       (m_we),
    .m_funct3   (m_funct3),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .stall_m    (stall_m),
    .load_data  (load_data),
    .done_m     (done_m),
    .bus_err    (bus_err),
`ifdef LSU_MISALIGN_CHK_EN
    .misalign   (misalign),
`endif
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [68:0] act, input logic [68:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_req && mem_gnt) begin
        if (exp_bus_q.size() == 0) begin
          check_cnt++;
          $display("FAIL bus_unexpected: got addr %h with no expected request", mem_addr);
        end else begin
          check("bus_req", {mem_we, mem_addr, mem_be, mem_wdata}, exp_bus_q.pop_front());
        end
      end
      if (done_m) begin
        if (exp_done_q.size() == 0) begin
          check_cnt++;
          $display("FAIL done_unexpected: got done_m=1 with no expected completion");
        end else begin
          logic [33:0] e;
          e = exp_done_q.pop_front();
          if (e[33]) check("load_result", {35'h0, bus_err, load_data}, {35'h0, e[32:0]});
          else       check("store_err", {68'h0, bus_err}, {68'h0, e[32]});
        end
      end
    end
  end

  // Driver: one M-stage access. gnt_dly<0 means never grant, rv_dly<=0 means never return data.
  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata, input logic [3:0] exp_be,
                        input logic [31:0] exp_wdata, input logic [31:0] exp_data,
                        input logic exp_err, input int exp_lat);
    int n;
    if (gnt_dly >= 0) exp_bus_q.push_back({we, addr[31:2], 2'b00, exp_be, exp_wdata});
    exp_done_q.push_back({~we, exp_err, exp_data});
    m_valid = 1'b1; m_we = we; m_funct3 = f3; m_addr = addr; m_wdata = wdata;
    #1;
    check("stall_on_issue", {68'h0, stall_m}, 69'h1);
    @(posedge clk); #1;
    check("req_raised", {68'h0, mem_req}, 69'h1);
    if (gnt_dly >= 0) begin
      repeat (gnt_dly) tick();
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0;
      if (!we && rv_dly > 0) begin
        repeat (rv_dly - 1) tick();
        mem_rvalid = 1'b1; mem_rdata = rdata;
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0;
      end
    end
    n = 0;
    while (!done_m && n < 20) begin
      tick();
      n++;
    end
    if (!done_m) begin
      check_cnt++;
      $display("FAIL done_timeout: got no done_m within %0d cycles, required a completion", n);
    end else begin
      check("done_latency", 69'(n), 69'(exp_lat));
      check("stall_released", {68'h0, stall_m}, 69'h0);
    end
    m_valid = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) tick();
    check("rst_outputs", {stall_m, done_m, bus_err, mem_req, mem_we, mem_be, load_data},
          {5'b0, 4'h0, 32'h0});
    rst = 1'b0;
    tick();
    check("idle_quiet", {stall_m, done_m, mem_req}, 69'h0);

    //     we  f3      addr          wdata         gnt rv rdata         be       wdata_exp     data          err lat
    access(1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 0, 0, 32'h0,         4'b1111, 32'hDEADBEEF, 32'h0,        0, 0);
    access(1, 3'b000, 32'h0000_0103, 32'h000000A5, 1, 0, 32'h0,         4'b1000, 32'hA5000000, 32'h0,        0, 0);
    access(0, 3'b000, 32'h0000_0102, 32'h0,        2, 3, 32'h1280FF00, 4'b1111, 32'h0,        32'hFFFFFF80, 0, 0);
    access(0, 3'b100, 32'h0000_0102, 32'h0,        0, 1, 32'h1280FF00, 4'b1111, 32'h0,        32'h00000080, 0, 0);
    access(0, 3'b101, 32'h0000_0102, 32'h0,        1, 2, 32'h80010000, 4'b1111, 32'h0,        32'h00008001, 0, 0);
    access(0, 3'b001, 32'h0000_0102, 32'h0,        0, 1, 32'h80010000, 4'b1111, 32'h0,        32'hFFFF8001, 0, 0);
    access(0, 3'b010, 32'h0000_0204, 32'h0,        0, 1, 32'hCAFEF00D, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 0);
    access(0, 3'b000, 32'h0000_0101, 32'h0,        0, 2, 32'h00007F00, 4'b1111, 32'h0,        32'h0000007F, 0, 0);
    access(0, 3'b011, 32'h0000_0308, 32'h0,        0, 1, 32'h11223344, 4'b1111, 32'h0,        32'h11223344, 0, 0);
    access(1, 3'b001, 32'h0000_0102, 32'h00001234, 0, 0, 32'h0,         4'b1100, 32'h12340000, 32'h0,        0, 0);
`ifndef LSU_MISALIGN_CHK_EN
    access(1, 3'b001, 32'h0000_0101, 32'h00001234, 0, 0, 32'h0,         4'b0110, 32'h00123400, 32'h0,        0, 0);
    access(0, 3'b001, 32'h0000_0003, 32'h0,        0, 1, 32'h7FFF0000, 4'b1111, 32'h0,        32'h00007FFF, 0, 0);
`else
    exp_done_q.push_back({1'b1, 1'b0, 32'h0});
    m_valid = 1'b1; m_we = 1'b0; m_funct3 = 3'b010; m_addr = 32'h102;
    tick();
    check("misalign_done", {done_m, misalign, mem_req, load_data}, {1'b1, 1'b1, 1'b0, 32'h0});
    m_valid = 1'b0;
    tick();
`endif
    // Data-phase timeout: granted load, no rvalid for MAXW cycles.
    access(0, 3'b010, 32'h0000_0400, 32'h0,        0, 0, 32'h0,         4'b1111, 32'h0,        32'h0,        1, MAXW);
    // Request-phase timeout: never granted.
    access(0, 3'b010, 32'h0000_0500, 32'h0,       -1, 0, 32'h0,         4'b1111, 32'h0,        32'h0,        1, MAXW);
    check("req_dropped", {68'h0, mem_req}, 69'h0);
    access(1, 3'b010, 32'h0000_0600, 32'h01020304, 0, 0, 32'h0,         4'b1111, 32'h01020304, 32'h0,        0, 0);

    // Reset while waiting for read data; late bus responses must be ignored.
    exp_bus_q.push_back({1'b0, 32'h0000_0700, 4'b1111, 32'h0});
    m_valid = 1'b1; m_we = 1'b0; m_funct3 = 3'b010; m_addr = 32'h700; m_wdata = 32'h0;
    tick();
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    m_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_wait", {stall_m, done_m, mem_req, load_data}, {3'b000, 32'h0});
    mem_rvalid = 1'b1; mem_gnt = 1'b1; mem_rdata = 32'hBAADF00D;
    tick();
    mem_rvalid = 1'b0; mem_gnt = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      check("late_rvalid_ignored", {done_m, mem_req, load_data}, {2'b00, 32'h0});
      tick();
    end

    check("bus_q_empty", 69'(exp_bus_q.size()), 69'h0);
    check("done_q_empty", 69'(exp_done_q.size()), 69'h0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

endmodule
